adder_4bit_checker: RTL and testbench

//   Synthesizable response checker for the 4-bit ripple adder; the receiving end of the

---
 rtl/adder_4bit_checker.sv | 151 +++++++++++++++
 tb/tb_adder_4bit_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_4bit_checker.sv
// Response checker for the 4-bit ripple adder: checks {cout,s} against a+b+cin, counts
// vectors/errors and reports a verdict. Optional coverage map: define ADDER_CHK_COVER_EN.
//
// state   | meaning
// IDLE    | waiting for start after reset
// RUN     | checking vectors on valid cycles
// DONE    | NUM_VEC vectors checked, verdict on pass
module adder_4bit_checker #(
  parameter int NUM_VEC = 512,
  parameter int ERR_W   = 8
) (
  input  logic             clk_50MHz,
  input  logic             rst_n,
  input  logic             start,
  input  logic             valid,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic             cin,
  input  logic [3:0]       s,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic [9:0]       vec_cnt,
  output logic [8:0]       first_fail,
  output logic             first_fail_v
`ifdef ADDER_CHK_COVER_EN
  ,
  output logic             cov_full
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [9:0] NUM_VEC_L = 10'(NUM_VEC);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_pass;
  logic             r_mismatch;
  logic [ERR_W-1:0] r_err_cnt;
  logic [9:0]       r_vec_cnt;
  logic [8:0]       r_first_fail;
  logic             r_first_fail_v;

  logic             w_start_acc;
  logic             w_chk;
  logic [4:0]       w_exp;
  logic             w_bad;
  logic [9:0]       w_vec_inc;
  logic             w_last;
  logic [ERR_W-1:0] w_err_next;
  logic [8:0]       w_idx;
  logic             w_cov_ok;

  assign w_start_acc = start && (r_state != ST_RUN);
  assign w_chk       = valid && (r_state == ST_RUN);
  assign w_exp       = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  // Case inequality so an X/Z on the adder outputs is flagged in simulation.
  assign w_bad       = ({cout, s} !== w_exp);
  assign w_vec_inc   = r_vec_cnt + 10'd1;
  assign w_last      = (w_vec_inc == NUM_VEC_L);
  assign w_err_next  = (w_bad && (r_err_cnt != '1)) ? r_err_cnt + ERR_W'(1) : r_err_cnt;
  assign w_idx       = {cin, a, b};

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (valid && w_last) w_state_next = ST_DONE;
      ST_DONE: if (start) w_state_next = ST_RUN;
      default: w_state_next = ST_IDLE;
    endcase
  end

`ifdef ADDER_CHK_COVER_EN
  logic [511:0] r_seen;
  logic [511:0] w_seen_next;
  logic         r_cov_full;

  always_comb begin
    w_seen_next        = r_seen;
    w_seen_next[w_idx] = 1'b1;
  end

  assign w_cov_ok = &w_seen_next;

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_seen     <= '0;
      r_cov_full <= 1'b0;
    end else if (w_start_acc) begin
      r_seen     <= '0;
      r_cov_full <= 1'b0;
    end else if (w_chk) begin
      r_seen     <= w_seen_next;
      r_cov_full <= &w_seen_next;
    end
  end

  assign cov_full = r_cov_full;
`else
  assign w_cov_ok = 1'b1;
`endif

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_pass         <= 1'b0;
      r_mismatch     <= 1'b0;
      r_err_cnt      <= '0;
      r_vec_cnt      <= '0;
      r_first_fail   <= '0;
      r_first_fail_v <= 1'b0;
    end else if (w_start_acc) begin
      r_pass         <= 1'b0;
      r_mismatch     <= 1'b0;
      r_err_cnt      <= '0;
      r_vec_cnt      <= '0;
      r_first_fail   <= '0;
      r_first_fail_v <= 1'b0;
    end else if (w_chk) begin
      r_vec_cnt  <= w_vec_inc;
      r_mismatch <= w_bad;
      r_err_cnt  <= w_err_next;
      if (w_bad && !r_first_fail_v) begin
        r_first_fail   <= w_idx;
        r_first_fail_v <= 1'b1;
      end
      if (w_last) r_pass <= (w_err_next == '0) && w_cov_ok;
    end else begin
      r_mismatch <= 1'b0;
    end
  end

  assign busy         = (r_state == ST_RUN);
  assign done         = (r_state == ST_DONE);
  assign pass         = r_pass;
  assign mismatch     = r_mismatch;
  assign err_cnt      = r_err_cnt;
  assign vec_cnt      = r_vec_cnt;
  assign first_fail   = r_first_fail;
  assign first_fail_v = r_first_fail_v;

endmodule

// File: tb/tb_adder_4bit_checker.sv
// Directed bench for adder_4bit_checker: an ERR_W=8 and an ERR_W=4 instance observe the
// same stimulus. Coverage checks are compiled in when ADDER_CHK_COVER_EN is defined.
module tb_adder_4bit_checker;

  logic       clk_50MHz = 1'b0;
  logic       rst_n     = 1'b0;
  logic       start     = 1'b0;
  logic       valid     = 1'b0;
  logic [3:0] a         = '0;
  logic [3:0] b         = '0;
  logic       cin       = 1'b0;
  logic [3:0] s         = '0;
  logic       cout      = 1'b0;

  logic       busy, done, pass, mismatch, first_fail_v;
  logic [7:0] err_cnt;
  logic [9:0] vec_cnt;
  logic [8:0] first_fail;
  logic       q_busy, q_done, q_pass, q_mismatch, q_first_fail_v;
  logic [3:0] q_err_cnt;
  logic [9:0] q_vec_cnt;
  logic [8:0] q_first_fail;
`ifdef ADDER_CHK_COVER_EN
  logic       cov_full, q_cov_full;
`endif

  int n_tests  = 0;
  int n_fail   = 0;
  int mm_count = 0;

  always #10 clk_50MHz = ~clk_50MHz;

  adder_4bit_checker #(.NUM_VEC(512), .ERR_W(8)) u_dut (
    .clk_50MHz(clk_50MHz), .rst_n(rst_n), .start(start), .valid(valid),
    .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .err_cnt(err_cnt), .vec_cnt(vec_cnt), .first_fail(first_fail),
    .first_fail_v(first_fail_v)
`ifdef ADDER_CHK_COVER_EN
    , .cov_full(cov_full)
`endif
  );

  adder_4bit_checker #(.NUM_VEC(512), .ERR_W(4)) u_dut_sat (
    .clk_50MHz(clk_50MHz), .rst_n(rst_n), .start(start), .valid(valid),
    .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
    .busy(q_busy), .done(q_done), .pass(q_pass), .mismatch(q_mismatch),
    .err_cnt(q_err_cnt), .vec_cnt(q_vec_cnt), .first_fail(q_first_fail),
    .first_fail_v(q_first_fail_v)
`ifdef ADDER_CHK_COVER_EN
    , .cov_full(q_cov_full)
`endif
  );

  always @(posedge clk_50MHz) begin
    #2;
    if (mismatch === 1'b1) mm_count++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start edge carries a deliberately wrong valid vector; it must not be checked.
  task automatic start_run();
    @(negedge clk_50MHz);
    start = 1'b1; valid = 1'b1;
    a = 4'h1; b = 4'h1; cin = 1'b0; s = 4'h0; cout = 1'b1;
    @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    start = 1'b0; valid = 1'b0;
    mm_count = 0;
    chk("start_busy", busy, 1);
    chk("start_vec", vec_cnt, 0);
    chk("start_err", err_cnt, 0);
    chk("start_done", done, 0);
    chk("start_pass", pass, 0);
  endtask

  // mode: 0 correct, 1 two bad sums, 2 cout stuck 0, 3 valid gaps + start, 4 a=5 for a=6
  task automatic drive_vec(input logic [8:0] idx, input int mode);
    logic [4:0] sum;
    @(negedge clk_50MHz);
    cin = idx[8]; a = idx[7:4]; b = idx[3:0];
    if (mode == 4 && idx[7:4] == 4'd6) a = 4'd5;
    sum  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    s    = sum[3:0];
    cout = sum[4];
    if (mode == 1 && (idx == 9'h034 || idx == 9'h199)) s = 4'hF;
    if (mode == 2) cout = 1'b0;
    valid = 1'b1;
    @(posedge clk_50MHz);
  endtask

  task automatic gap(input logic with_start);
    @(negedge clk_50MHz);
    valid = 1'b0;
    start = with_start;
    a = 4'hF; b = 4'hF; cin = 1'b1; s = 4'h0; cout = 1'b0;
    @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    start = 1'b0;
  endtask

  task automatic run_full(input int mode);
    start_run();
    for (int i = 0; i < 512; i++) begin
      if (mode == 3) begin
        if (i == 100) begin
          gap(1'b1);
          chk("midrun_start_vec", vec_cnt, 100);
          chk("midrun_start_busy", busy, 1);
        end else begin
          repeat ($urandom_range(0, 2)) gap(1'b0);
        end
      end
      drive_vec(9'(i), mode);
      if (i == 510) chk("not_done_before_last", done, 0);
    end
    @(negedge clk_50MHz);
    valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk_50MHz);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_vec", vec_cnt, 0);
    chk("rst_ffv", first_fail_v, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50MHz);
    chk("idle_busy", busy, 0);

    // 1) clean full-space run
    run_full(0);
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_pass", pass, 1);
    chk("t1_err", err_cnt, 0);
    chk("t1_vec", vec_cnt, 512);
    chk("t1_ffv", first_fail_v, 0);
    chk("t1_mm_count", mm_count, 0);
`ifdef ADDER_CHK_COVER_EN
    chk("t1_cov_full", cov_full, 1);
`endif
    // valid in DONE is ignored
    a = 4'h2; b = 4'h2; cin = 1'b0; s = 4'h0; cout = 1'b1; valid = 1'b1;
    repeat (2) @(negedge clk_50MHz);
    valid = 1'b0;
    chk("t1_done_hold_vec", vec_cnt, 512);
    chk("t1_done_hold_err", err_cnt, 0);
    chk("t1_done_hold_pass", pass, 1);
    chk("t1_done_no_mm", mismatch, 0);

    // 2) two bad sums
    run_full(1);
    chk("t2_done", done, 1);
    chk("t2_err", err_cnt, 2);
    chk("t2_first_fail", first_fail, 9'h034);
    chk("t2_ffv", first_fail_v, 1);
    chk("t2_pass", pass, 0);
    chk("t2_mm_count", mm_count, 2);
    chk("t2_vec", vec_cnt, 512);

    // 3) cout stuck at 0: 256 bad vectors saturate both counters
    run_full(2);
    chk("t3_err8", err_cnt, 255);
    chk("t3_err4", q_err_cnt, 15);
    chk("t3_pass8", pass, 0);
    chk("t3_pass4", q_pass, 0);
    chk("t3_first_fail", first_fail, 9'h01F);

    // 4) reset mid-run at vector 200
    start_run();
    for (int i = 0; i < 200; i++) drive_vec(9'(i), 2);
    @(negedge clk_50MHz);
    valid = 1'b0;
    chk("t4_vec200", vec_cnt, 200);
    chk("t4_err70", err_cnt, 70);
    chk("t4_err4_sat", q_err_cnt, 15);
    #5 rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_done", done, 0);
    chk("t4_rst_err", err_cnt, 0);
    chk("t4_rst_vec", vec_cnt, 0);
    chk("t4_rst_ffv", first_fail_v, 0);
    chk("t4_rst_ff", first_fail, 0);
    @(negedge clk_50MHz);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_50MHz);
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_done", done, 0);
    run_full(0);
    chk("t4_rerun_pass", pass, 1);
    chk("t4_rerun_vec", vec_cnt, 512);

    // 5) valid gaps and ignored start
    run_full(3);
    chk("t5_done", done, 1);
    chk("t5_vec", vec_cnt, 512);
    chk("t5_err", err_cnt, 0);
    chk("t5_pass", pass, 1);

`ifdef ADDER_CHK_COVER_EN
    // 6) a=6 never seen
    run_full(4);
    chk("t6_done", done, 1);
    chk("t6_err", err_cnt, 0);
    chk("t6_cov_full", cov_full, 0);
    chk("t6_pass", pass, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
